// File: rtl/regfile_checker_pkg.sv
// Shared types and helpers for the regfile checker.
//   state_t  : controller phases
//   lane_lo  : bit offset of a lane inside a flattened multi-lane bus
//   popcount : number of set bits in a (zero-extended) per-lane flag vector
package regfile_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRST,
        RUN,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    // Upper bound on lanes accepted by popcount; callers zero-extend to this width.
    localparam int MAX_LANES = 64;

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    function automatic logic [6:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < MAX_LANES; i++) c = c + {6'd0, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/regfile_checker_lane_cmp.sv
// One compare lane of the regfile checker.
//   clock, reset : system clock, synchronous active-low reset
//   cap          : capture act_in at the end of this cycle (scan beat)
//   chk_vld      : exp_in lines up with the captured value this cycle
//   chk_en       : compare mode; 0 forces the mismatch flag low
//   act_in       : regfile read data for this lane
//   exp_in       : expected value for this lane (one cycle after cap)
//   act          : captured actual value, held between beats
//   mis          : mismatch flag; live while chk_vld, last result otherwise
module checker_lane_cmp #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cap,
    input  logic              chk_vld,
    input  logic              chk_en,
    input  logic [DATA_W-1:0] act_in,
    input  logic [DATA_W-1:0] exp_in,
    output logic [DATA_W-1:0] act,
    output logic              mis
);

    logic [DATA_W-1:0] act_q;
    logic              mis_q;
    logic              live;

    // exp_in comes straight from the synchronous expected memory, so the
    // compare is only meaningful in the cycle flagged by chk_vld.
    assign live = chk_en && (act_q != exp_in);

    always_ff @(posedge clock) begin
        if (!reset) begin
            act_q <= '0;
            mis_q <= 1'b0;
        end else begin
            if (cap)     act_q <= act_in;
            if (chk_vld) mis_q <= live;
        end
    end

    assign act = act_q;
    assign mis = chk_vld ? live : mis_q;

endmodule

// File: rtl/regfile_checker.sv
// Processor bring-up checker: holds the core in reset, lets it run for
// num_cycles, counts regfile commits, then takes over the regfile read
// ports and compares every register against an expected-value memory.
//   clock, reset      : system clock, synchronous active-low reset
//   start             : begin a run (IDLE/DONE only); samples num_cycles, verify_en
//   commit_we/rd      : snooped processor regfile writes
//   proc_reset        : active-high processor reset
//   test_mode         : regfile read-port mux select (1 = checker addresses)
//   scan_addr/data    : regfile read ports, one per lane
//   exp_addr/data     : expected memory, synchronous 1-cycle read
//   rec_*             : one compare record per scan beat
//   write_count       : saturating count of rd != 0 commits during RUN
//   errors            : total mismatching registers
//   done              : run complete
module regfile_checker
    import regfile_checker_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_LANES = 1,
    parameter int CYC_W     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [CYC_W-1:0]              num_cycles,
    input  logic                          verify_en,
    input  logic                          commit_we,
    input  logic [ADDR_W-1:0]             commit_rd,
    output logic                          proc_reset,
    output logic                          test_mode,
    output logic [NUM_LANES*ADDR_W-1:0]   scan_addr,
    input  logic [NUM_LANES*DATA_W-1:0]   scan_data,
    output logic [ADDR_W-1:0]             exp_addr,
    input  logic [NUM_LANES*DATA_W-1:0]   exp_data,
    output logic                          rec_valid,
    output logic [ADDR_W-1:0]             rec_base,
    output logic [NUM_LANES*DATA_W-1:0]   rec_act,
    output logic [NUM_LANES-1:0]          rec_mismatch,
    output logic [CYC_W-1:0]              write_count,
    output logic [ADDR_W:0]               errors,
    output logic                          done
);

    localparam int ERR_W  = ADDR_W + 1;
    localparam int STAGES = 0;
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(NUM_REGS - NUM_LANES);

    state_t state, nxt;

    logic [CYC_W-1:0]                    ncyc_q;
    logic                                ver_q;
    logic [CYC_W-1:0]                    cnt_q;
    logic [NUM_LANES-1:0][ADDR_W-1:0]    addr_q;
    logic [ADDR_W-1:0]                   rec_base_q;
    logic [STAGES:0]                     vld_pipe;
    logic [ERR_W-1:0]                    errors_q;
    logic [CYC_W-1:0]                    wc_q;
    logic                                proc_reset_q;
    logic                                test_mode_q;
    logic                                done_q;
    logic [NUM_LANES-1:0][DATA_W-1:0]    act_w;
    logic [NUM_LANES-1:0]                mis_w;

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: if (start) nxt = PRST;
            PRST:       nxt = (ncyc_q == '0) ? SCAN : RUN;
            RUN:        if (cnt_q == ncyc_q - CYC_W'(1)) nxt = SCAN;
            SCAN:       if (addr_q[0] == LAST_BASE) nxt = DRAIN;
            DRAIN:      nxt = DONE;
            default:    nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            ncyc_q       <= '0;
            ver_q        <= 1'b0;
            cnt_q        <= '0;
            addr_q       <= '0;
            rec_base_q   <= '0;
            vld_pipe     <= '0;
            errors_q     <= '0;
            wc_q         <= '0;
            proc_reset_q <= 1'b1;
            test_mode_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state <= nxt;
            // Control outputs are registered from the next state so they
            // change on the same edge as the state itself.
            proc_reset_q <= (nxt != RUN);
            test_mode_q  <= (nxt == SCAN) || (nxt == DRAIN);
            done_q       <= (nxt == DONE);
            // The beat issued this cycle is compared (and recorded) next cycle.
            vld_pipe[0]  <= (state == SCAN);

            if (start && (state == IDLE || state == DONE)) begin
                ncyc_q <= num_cycles;
                ver_q  <= verify_en;
            end

            case (state)
                PRST: begin
                    cnt_q    <= '0;
                    errors_q <= '0;
                    wc_q     <= '0;
                    for (int i = 0; i < NUM_LANES; i++) addr_q[i] <= ADDR_W'(i);
                end
                RUN: begin
                    cnt_q <= cnt_q + CYC_W'(1);
                    if (commit_we && commit_rd != '0 && wc_q != '1)
                        wc_q <= wc_q + CYC_W'(1);
                end
                SCAN: begin
                    rec_base_q <= addr_q[0];
                    for (int i = 0; i < NUM_LANES; i++)
                        addr_q[i] <= addr_q[i] + ADDR_W'(NUM_LANES);
                end
                default: ;
            endcase

            if (vld_pipe[0])
                errors_q <= errors_q + ERR_W'(popcount(MAX_LANES'(mis_w)));
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        checker_lane_cmp #(.DATA_W(DATA_W)) u_cmp (
            .clock   (clock),
            .reset   (reset),
            .cap     (state == SCAN),
            .chk_vld (vld_pipe[0]),
            .chk_en  (ver_q),
            .act_in  (scan_data[lane_lo(g, DATA_W) +: DATA_W]),
            .exp_in  (exp_data[lane_lo(g, DATA_W) +: DATA_W]),
            .act     (act_w[g]),
            .mis     (mis_w[g])
        );
    end

    assign proc_reset   = proc_reset_q;
    assign test_mode    = test_mode_q;
    assign scan_addr    = addr_q;
    assign exp_addr     = addr_q[0];
    assign rec_valid    = vld_pipe[0];
    assign rec_base     = rec_base_q;
    assign rec_act      = act_w;
    assign rec_mismatch = mis_w;
    assign write_count  = wc_q;
    assign errors       = errors_q;
    assign done         = done_q;

endmodule

// File: tb/tb_regfile_checker.sv
module tb_regfile_checker;
    localparam int DW = 32, NR = 32, AW = 5, CW = 16, LB = 4;

    logic clock = 1'b0;
    logic reset, start, verify_en, commit_we;
    logic [CW-1:0] num_cycles;
    logic [AW-1:0] commit_rd;

    always #5 clock = ~clock;

    // single-lane instance
    logic pr_a, tm_a, rv_a, dn_a, rm_a;
    logic [AW-1:0] sa_a, ea_a, rb_a;
    logic [DW-1:0] sd_a, ed_a, ra_a;
    logic [CW-1:0] wc_a;
    logic [AW:0]   er_a;
    // four-lane instance
    logic pr_b, tm_b, rv_b, dn_b;
    logic [LB*AW-1:0] sa_b;
    logic [AW-1:0] ea_b, rb_b;
    logic [LB*DW-1:0] sd_b, ed_b, ra_b;
    logic [LB-1:0] rm_b;
    logic [CW-1:0] wc_b;
    logic [AW:0]   er_b;

    logic [DW-1:0] regs [NR];
    logic [DW-1:0] expv [NR];

    int nchk = 0, nerr = 0;

    regfile_checker #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_LANES(1), .CYC_W(CW)) dut_a (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles), .verify_en(verify_en),
        .commit_we(commit_we), .commit_rd(commit_rd), .proc_reset(pr_a), .test_mode(tm_a),
        .scan_addr(sa_a), .scan_data(sd_a), .exp_addr(ea_a), .exp_data(ed_a),
        .rec_valid(rv_a), .rec_base(rb_a), .rec_act(ra_a), .rec_mismatch(rm_a),
        .write_count(wc_a), .errors(er_a), .done(dn_a));

    regfile_checker #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_LANES(LB), .CYC_W(CW)) dut_b (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles), .verify_en(verify_en),
        .commit_we(commit_we), .commit_rd(commit_rd), .proc_reset(pr_b), .test_mode(tm_b),
        .scan_addr(sa_b), .scan_data(sd_b), .exp_addr(ea_b), .exp_data(ed_b),
        .rec_valid(rv_b), .rec_base(rb_b), .rec_act(ra_b), .rec_mismatch(rm_b),
        .write_count(wc_b), .errors(er_b), .done(dn_b));

    // regfile: combinational read; expected memory: 1-cycle synchronous read
    assign sd_a = regs[sa_a];
    always_comb begin
        sd_b = '0;
        for (int i = 0; i < LB; i++) sd_b[i*DW +: DW] = regs[sa_b[i*AW +: AW]];
    end
    always @(posedge clock) begin
        ed_a <= expv[ea_a];
        for (int i = 0; i < LB; i++) ed_b[i*DW +: DW] <= expv[ea_b + AW'(i)];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int nmis);
        int idx;
        for (int j = 0; j < NR; j++) begin
            regs[j] = $urandom;
            expv[j] = regs[j];
        end
        for (int m = 0; m < nmis; m++) begin
            idx = $urandom_range(0, NR-1);
            expv[idx] = regs[idx] ^ (32'd1 << $urandom_range(0, 31));
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_prst_a"}, 64'(pr_a), 64'd1);
        chk({tag, "_tm_a"},   64'(tm_a), 64'd0);
        chk({tag, "_done_a"}, 64'(dn_a), 64'd0);
        chk({tag, "_err_a"},  64'(er_a), 64'd0);
        chk({tag, "_wc_a"},   64'(wc_a), 64'd0);
        chk({tag, "_rv_a"},   64'(rv_a), 64'd0);
        chk({tag, "_rm_a"},   64'(rm_a), 64'd0);
        chk({tag, "_prst_b"}, 64'(pr_b), 64'd1);
        chk({tag, "_tm_b"},   64'(tm_b), 64'd0);
        chk({tag, "_done_b"}, 64'(dn_b), 64'd0);
        chk({tag, "_err_b"},  64'(er_b), 64'd0);
        chk({tag, "_rv_b"},   64'(rv_b), 64'd0);
    endtask

    // One run on both instances. Cycle k counts edges after the start edge:
    // k=0 PRST, 1..n RUN, then NR/lanes SCAN beats, one DRAIN, then DONE.
    // cmode: 0 no commits, 1 rd=3 then rd=0, 2 random every cycle.
    task automatic run(input int n, input bit ver, input int cmode, input int start_at, input int abort_at);
        int wc, nexp, r, ra, rb;
        logic [LB-1:0] mm;
        wc = 0;
        nexp = 0;
        for (int j = 0; j < NR; j++) if (ver && regs[j] !== expv[j]) nexp++;
        start = 1'b1;
        num_cycles = CW'(n);
        verify_en = ver;
        @(posedge clock); #1;
        start = 1'b0;
        num_cycles = CW'($urandom);
        verify_en = 1'($urandom);
        for (int k = 0; k <= n + NR + 2; k++) begin
            commit_we = 1'b0;
            commit_rd = '0;
            if (cmode == 1) begin
                if (k == 1) begin commit_we = 1'b1; commit_rd = 5'd3; end
                if (k == 2) begin commit_we = 1'b1; commit_rd = 5'd0; end
            end else if (cmode == 2) begin
                commit_we = 1'($urandom);
                commit_rd = AW'($urandom);
            end
            if (k >= 1 && k <= n && commit_we && commit_rd != '0) wc++;
            start = (k == start_at);
            if (k == abort_at) reset = 1'b0;
            @(negedge clock);
            chk("prst_a",  64'(pr_a), 64'(!(k >= 1 && k <= n)));
            chk("tmode_a", 64'(tm_a), 64'(k >= n+1 && k <= n+NR+1));
            chk("done_a",  64'(dn_a), 64'(k >= n+NR+2));
            chk("rvld_a",  64'(rv_a), 64'(k >= n+2 && k <= n+NR+1));
            chk("prst_b",  64'(pr_b), 64'(!(k >= 1 && k <= n)));
            chk("tmode_b", 64'(tm_b), 64'(k >= n+1 && k <= n+NR/LB+1));
            chk("done_b",  64'(dn_b), 64'(k >= n+NR/LB+2));
            chk("rvld_b",  64'(rv_b), 64'(k >= n+2 && k <= n+NR/LB+1));
            if (k == 1) begin
                chk("clr_err_a", 64'(er_a), 64'd0);
                chk("clr_err_b", 64'(er_b), 64'd0);
                chk("clr_wc_a",  64'(wc_a), 64'd0);
            end
            r = k - (n + 2);
            if (rv_a && r >= 0 && r < NR) begin
                chk("base_a", 64'(rb_a), 64'(r));
                chk("act_a",  64'(ra_a), 64'(regs[r]));
                chk("mis_a",  64'(rm_a), 64'(ver && regs[r] !== expv[r]));
            end
            if (rv_b && r >= 0 && r < NR/LB) begin
                chk("base_b", 64'(rb_b), 64'(r*LB));
                for (int i = 0; i < LB; i++) begin
                    chk("act_b", 64'(ra_b[i*DW +: DW]), 64'(regs[r*LB+i]));
                    mm[i] = ver && (regs[r*LB+i] !== expv[r*LB+i]);
                end
                chk("mis_b", 64'(rm_b), 64'(mm));
            end
            if (k == abort_at) begin
                @(posedge clock); #1;
                reset = 1'b1;
                start = 1'b0;
                @(negedge clock);
                chk_idle("abort");
                @(posedge clock); #1;
                return;
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
        commit_we = 1'b0;
        chk("wc_a",  64'(wc_a), 64'(wc));
        chk("wc_b",  64'(wc_b), 64'(wc));
        chk("err_a", 64'(er_a), 64'(nexp));
        chk("err_b", 64'(er_b), 64'(nexp));
        // records hold the final beat once scanning has finished
        ra = NR - 1;
        rb = NR - LB;
        chk("hold_base_a", 64'(rb_a), 64'(ra));
        chk("hold_base_b", 64'(rb_b), 64'(rb));
        chk("hold_mis_a",  64'(rm_a), 64'(ver && regs[ra] !== expv[ra]));
        for (int i = 0; i < LB; i++) mm[i] = ver && (regs[rb+i] !== expv[rb+i]);
        chk("hold_mis_b",  64'(rm_b), 64'(mm));
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        verify_en = 1'b0;
        num_cycles = '0;
        commit_we = 1'b0;
        commit_rd = '0;
        fill(0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk_idle("reset");
        chk("rst_base_a", 64'(rb_a), 64'd0);
        chk("rst_act_b",  64'(ra_b), 64'd0);
        chk("rst_saddr_b", 64'(sa_b), 64'd0);
        chk("rst_eaddr_a", 64'(ea_a), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // all registers match, deterministic commits
        run(4, 1'b1, 1, -1, -1);
        chk("t1_wc", 64'(wc_a), 64'd1);

        // single bad register 7
        fill(0);
        regs[7] = 32'd6;
        expv[7] = 32'd5;
        run(6, 1'b1, 2, -1, -1);
        chk("t2_err", 64'(er_a), 64'd1);

        // dump-only on the same data; start during RUN is ignored
        run(3, 1'b0, 2, 2, -1);

        // registers 8 and 10 wrong: one four-lane beat carries both
        fill(0);
        expv[8]  = ~regs[8];
        expv[10] = regs[10] + 32'd1;
        run(5, 1'b1, 2, -1, -1);
        chk("t4_err_b", 64'(er_b), 64'd2);

        // reset during SCAN beat 5, then a normal run from IDLE
        fill(0);
        expv[2] = ~regs[2];
        run(3, 1'b1, 2, -1, 3 + 1 + 5);
        run(2, 1'b1, 2, -1, -1);

        // zero run length; start during SCAN ignored; restart from DONE
        fill(3);
        run(0, 1'b1, 2, 5, -1);
        chk("t6_wc", 64'(wc_a), 64'd0);
        run(7, 1'b1, 2, -1, -1);

        // random runs
        for (int t = 0; t < 3; t++) begin
            fill($urandom_range(0, 6));
            run($urandom_range(0, 20), 1'($urandom), 2, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
